// File: rtl/tx_fifo_module.sv
// tx_fifo_module: byte FIFO feeding a UART transmitter with a one-cycle inter-byte gap; TX_FIFO_OVERFLOW_FLAG_EN enables the sticky overflow flag
module tx_fifo_module #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Wr_En,
  input  logic [7:0]        Wr_Data,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Tx_Busy,
  output logic              Tx_En_Sig,
  output logic [7:0]        Tx_Data,
  input  logic              Tx_Done_Sig,
  output logic              Overflow_Sig
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_ok, pop;
  logic [ADDR_W:0]   count_nxt;
  assign wr_ok     = Wr_En && !Full;
  assign pop       = state == IDLE && !Empty;
  assign count_nxt = Count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
  // storage write; contents are not cleared by reset
  always_ff @(posedge CLK)
    if (wr_ok) mem[wr_ptr] <= Wr_Data;
  // write pointer, occupancy and flags kept in step with the next count
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      wr_ptr <= '0;
      Count  <= '0;
      Full   <= 1'b0;
      Empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + ADDR_W'(1) : wr_ptr;
      Count  <= count_nxt;
      Full   <= count_nxt == (ADDR_W+1)'(DEPTH);
      Empty  <= count_nxt == '0;
    end
  // transmit sequencer: pop head into SEND, hold until done, one GAP cycle, back to IDLE
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      Tx_En_Sig <= 1'b0;
      Tx_Data   <= 8'h00;
      Tx_Busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!Empty) begin
          Tx_Data   <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + ADDR_W'(1);
          Tx_En_Sig <= 1'b1;
          Tx_Busy   <= 1'b1;
          state     <= SEND;
        end
        SEND: if (Tx_Done_Sig) begin
          Tx_En_Sig <= 1'b0;
          state     <= GAP;
        end
        GAP: begin
          Tx_Busy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          Tx_En_Sig <= 1'b0;
          Tx_Busy   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
  // sticky flag set by any write attempted while full
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) Overflow_Sig <= 1'b0;
    else if (Wr_En && Full) Overflow_Sig <= 1'b1;
`else
  assign Overflow_Sig = 1'b0;
`endif
endmodule

// File: tb/tb_tx_fifo_module.sv
// tb_tx_fifo_module: randomized and directed checks of tx_fifo_module against a queue-based reference model
module tb_tx_fifo_module;
  localparam int DEPTH = 16, ADDR_W = 4;
`ifdef TX_FIFO_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic CLK = 1'b0, RST_n = 1'b0, Wr_En = 1'b0, Tx_Done_Sig = 1'b0;
  logic [7:0] Wr_Data = 8'h00;
  logic Full, Empty, Tx_Busy, Tx_En_Sig, Overflow_Sig;
  logic [ADDR_W:0] Count;
  logic [7:0] Tx_Data;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] exp_bytes[$];
  logic m_en, m_busy, m_ovf;
  logic [7:0] m_data;
  logic prev_en, gap_chk, seen_byte;
  int low_run, hi_cnt;

  tx_fifo_module #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_n(RST_n), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
    .Full(Full), .Empty(Empty), .Count(Count), .Tx_Busy(Tx_Busy),
    .Tx_En_Sig(Tx_En_Sig), .Tx_Data(Tx_Data), .Tx_Done_Sig(Tx_Done_Sig),
    .Overflow_Sig(Overflow_Sig)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, req, $time);
    end
  endtask

  task automatic model_clear;
    q.delete();
    m_en = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
    prev_en = 1'b0; low_run = 0; hi_cnt = 0; seen_byte = 1'b0;
  endtask

  task automatic check_all;
    chk("count", 32'(Count), 32'(q.size()));
    chk("empty", 32'(Empty), 32'(q.size() == 0));
    chk("full", 32'(Full), 32'(q.size() == DEPTH));
    chk("tx_en", 32'(Tx_En_Sig), 32'(m_en));
    chk("tx_data", 32'(Tx_Data), 32'(m_data));
    chk("busy", 32'(Tx_Busy), 32'(m_busy));
    chk("ovf", 32'(Overflow_Sig), 32'(m_ovf));
  endtask

  // one clock: apply inputs, advance the model by one edge, compare
  task automatic step(input logic wr, input logic [7:0] d, input logic done);
    bit full_pre, empty_pre;
    Wr_En = wr; Wr_Data = d; Tx_Done_Sig = done;
    @(posedge CLK);
    full_pre  = q.size() == DEPTH;
    empty_pre = q.size() == 0;
    if (!m_busy && !empty_pre) begin
      m_data = q.pop_front(); m_en = 1'b1; m_busy = 1'b1;
    end else if (m_en && done) m_en = 1'b0;
    else if (m_busy && !m_en) m_busy = 1'b0;
    if (wr && !full_pre) q.push_back(d);
    if (OVF_EN && wr && full_pre) m_ovf = 1'b1;
    #1;
    check_all();
    if (Tx_En_Sig && !prev_en) begin
      got.push_back(Tx_Data);
      if (gap_chk && seen_byte) chk("gap_low", 32'(low_run), 32'd2);
      seen_byte = 1'b1; low_run = 0; hi_cnt = 0;
    end else if (!Tx_En_Sig) low_run++;
    else hi_cnt++;
    prev_en = Tx_En_Sig;
  endtask

  task automatic do_reset;
    Wr_En = 1'b0; Tx_Done_Sig = 1'b0;
    RST_n = 1'b0;
    model_clear();
    got.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all();
    RST_n = 1'b1;
  endtask

  initial begin
    gap_chk = 1'b0;
    do_reset();
    // single byte latency
    step(1'b1, 8'h55, 1'b0);
    chk("w1_count", 32'(Count), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("w1_en", 32'(Tx_En_Sig), 32'd1);
    chk("w1_data", 32'(Tx_Data), 32'h55);
    chk("w1_empty", 32'(Empty), 32'd1);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, Tx_En_Sig && hi_cnt == 10);
    chk("w1_idle", 32'(Tx_Busy), 32'd0);
    // three back-to-back bytes, done 10 cycles after each rise
    do_reset();
    gap_chk = 1'b1;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, 8'h00, Tx_En_Sig && hi_cnt == 10);
    gap_chk = 1'b0;
    chk("seq_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("seq0", 32'(got[0]), 32'hA1);
      chk("seq1", 32'(got[1]), 32'hA2);
      chk("seq2", 32'(got[2]), 32'hA3);
    end
    chk("seq_busy", 32'(Tx_Busy), 32'd0);
    // fill to full while the transmitter is stalled
    do_reset();
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 32), 1'b0);
    chk("full16", 32'(Full), 32'd1);
    step(1'b1, 8'hEE, 1'b0);
    chk("drop_count", 32'(Count), 32'd16);
    chk("drop_ovf", 32'(Overflow_Sig), 32'(OVF_EN));
    // simultaneous write and pop at count 5
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 2), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    chk("same_cycle", 32'(Count), 32'd5);
    // asynchronous reset in the middle of SEND
    chk("pre_rst_en", 32'(Tx_En_Sig), 32'd1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("rst_async_en", 32'(Tx_En_Sig), 32'd0);
    chk("rst_async_cnt", 32'(Count), 32'd0);
    model_clear();
    got.delete();
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0);
    chk("rst_no_stale", 32'(got.size()), 32'd0);
    // 40 random bytes with random done pulses, across pointer wrap
    do_reset();
    exp_bytes.delete();
    for (int c = 0; c < 3000 && !(exp_bytes.size() == 40 && got.size() == 40 && !m_busy); c++) begin
      logic w;
      logic [7:0] d;
      w = exp_bytes.size() < 40 && $urandom_range(0, 1) == 1 && q.size() < DEPTH;
      d = 8'($urandom);
      if (w) exp_bytes.push_back(d);
      step(w, d, $urandom_range(0, 3) == 0);
    end
    chk("n_out", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("order", 32'(got[i]), 32'(exp_bytes[i]));
    chk("final_count", 32'(Count), 32'd0);
    // random stress with frequent overflow
    for (int c = 0; c < 400; c++) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
